// File: rtl/rom_pair_pkg.sv
// -----------------------------------------------------------------------------
// rom_pair_pkg
// Shared definitions for the ROM pair accumulator:
//   state_e   - sequencer states (idle, issuing addresses, draining the pipe)
//   sum_width - result width that cannot overflow over a whole pass
// -----------------------------------------------------------------------------
package rom_pair_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   // A full pass adds 2**addr_w pairs, each below 2**(data_w+1), so the
   // running total always fits in data_w + addr_w + 1 bits.
   function automatic int unsigned sum_width(input int unsigned data_w,
                                             input int unsigned addr_w);
      return data_w + addr_w + 1;
   endfunction

endpackage

// File: rtl/sync_rom.sv
// -----------------------------------------------------------------------------
// sync_rom
// Single-port ROM with a registered read. Contents live in MEM and are
// preloaded from outside (e.g. by a hierarchical write).
// Ports:
//   clock - rising-edge clock
//   en    - read enable; data holds its last value while low
//   addr  - read address
//   data  - registered read data, valid the cycle after addr is presented
// -----------------------------------------------------------------------------
module sync_rom #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clock,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] MEM [2**ADDR_W];
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clock) begin
      if (en) begin
         data_q <= MEM[addr];
      end
   end

   assign data = data_q;

endmodule

// File: rtl/rom_pair_accumulator.sv
// -----------------------------------------------------------------------------
// rom_pair_accumulator
// Walks an address counter through two identical ROM banks (A and B), adds
// each addressed pair and either reports the per-pair sum (accum=0) or a
// running total for the current pass (accum=1). Passes run once or loop
// continuously under a start/busy/done handshake.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset
//   start     - request a pass, only honoured when idle
//   accum     - 0 = per-pair sum, 1 = running accumulate (latched at start)
//   loop      - 1 = wrap to address 0 after the last address, 0 = stop there
//   address   - current ROM address
//   sum       - registered result; holds while sum_valid is low
//   sum_valid - sum was updated this cycle
//   busy      - pass in progress (issuing or draining)
//   done      - one-cycle pulse alongside the final sum of a terminated pass
// Pipeline: address -> ROM read register (stage 1) -> sum register (stage 2).
// -----------------------------------------------------------------------------
module rom_pair_accumulator
   import rom_pair_pkg::*;
#(
   parameter int unsigned  DATA_W = 8,
   parameter int unsigned  ADDR_W = 4,
   localparam int unsigned SUM_W  = sum_width(DATA_W, ADDR_W)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              accum,
   input  logic              loop,
   output logic [ADDR_W-1:0] address,
   output logic [SUM_W-1:0]  sum,
   output logic              sum_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LastAddr = '1;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              accum_q;

   // Stage 1 tags travel alongside the registered ROM data.
   logic              v1_q;
   logic              first1_q;

   // Stage 2 results.
   logic [SUM_W-1:0]  sum_q;
   logic              sum_valid_q;
   logic              done_q;

   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;
   logic [DATA_W:0]   pair;
   logic [SUM_W-1:0]  pair_ext;
   logic              rom_en;

   assign rom_en = (state_q == StRun);

   sync_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) A1 (
      .clock (clock),
      .en    (rom_en),
      .addr  (addr_q),
      .data  (a_data)
   );

   sync_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) B1 (
      .clock (clock),
      .en    (rom_en),
      .addr  (addr_q),
      .data  (b_data)
   );

   assign pair     = {1'b0, a_data} + {1'b0, b_data};
   assign pair_ext = SUM_W'(pair);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         accum_q     <= 1'b0;
         v1_q        <= 1'b0;
         first1_q    <= 1'b0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Stage 1: the ROMs capture addr_q this edge whenever we are issuing.
         v1_q     <= (state_q == StRun);
         first1_q <= (addr_q == '0);

         // Stage 2: address 0 opens a pass, so the running total restarts there
         // (covers both a fresh start and a loop wrap).
         sum_valid_q <= v1_q;
         done_q      <= 1'b0;
         if (v1_q) begin
            sum_q <= (accum_q && !first1_q) ? sum_q + pair_ext : pair_ext;
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  addr_q  <= '0;
                  accum_q <= accum;
               end
            end
            StRun: begin
               if (addr_q == LastAddr) begin
                  if (loop) begin
                     addr_q <= '0;
                  end else begin
                     state_q <= StDrain;
                  end
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            StDrain: begin
               // The only sample still in flight is the last address of the pass.
               if (v1_q) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign address   = addr_q;
   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign done      = done_q;
   assign busy      = (state_q == StRun) || (state_q == StDrain);

endmodule

// File: tb/tb_rom_pair_accumulator.sv
// -----------------------------------------------------------------------------
// tb_rom_pair_accumulator
// Directed bench: each scenario is expanded into a table of per-cycle input
// and expected-output records, then replayed and compared one edge at a time.
// The asynchronous reset abort is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_rom_pair_accumulator;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned SUM_W  = 13;
   localparam int          DEPTH  = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              accum = 1'b0;
   logic              loop  = 1'b0;
   logic [ADDR_W-1:0] address;
   logic [SUM_W-1:0]  sum;
   logic              sum_valid;
   logic              busy;
   logic              done;

   always #5 clock = ~clock;

   rom_pair_accumulator #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .accum     (accum),
      .loop      (loop),
      .address   (address),
      .sum       (sum),
      .sum_valid (sum_valid),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic              start;
      logic              accum;
      logic              loop;
      logic [ADDR_W-1:0] addr;
      logic              busy;
      logic              valid;
      logic              done;
      logic [SUM_W-1:0]  sum;
   } vec_t;

   vec_t             tbl[$];
   logic [7:0]       rom_a [DEPTH];
   logic [7:0]       rom_b [DEPTH];
   logic [SUM_W-1:0] hold_sum;
   int               n_checks = 0;
   int               n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic load_rom(input bit all_ff);
      for (int i = 0; i < DEPTH; i++) begin
         rom_a[i] = all_ff ? 8'hFF : 8'(i);
         rom_b[i] = all_ff ? 8'hFF : 8'(2 * i);
         dut.A1.MEM[i] = rom_a[i];
         dut.B1.MEM[i] = rom_b[i];
      end
   endtask

   // Record j holds the inputs sampled at edge k+j and the outputs expected
   // after it, where k is the edge that samples start. loop stays high until
   // the final last-address decision, so `passes` passes run back to back.
   task automatic build_run(input int passes, input bit mode, input bit pulse, input int tail);
      int               n;
      logic [SUM_W-1:0] run;
      logic [SUM_W-1:0] hold;
      logic [SUM_W-1:0] pr;
      n    = DEPTH * passes;
      hold = hold_sum;
      run  = '0;
      tbl.delete();
      for (int j = 0; j <= n + 1 + tail; j++) begin
         vec_t v;
         int   idx;
         // Extra start pulses land in RUN (j=5) and in DRAIN (j=n+1).
         v.start = (j == 0) || (pulse && (j == 5 || j == n + 1));
         // Mode is flipped after the start edge; only the latched value counts.
         v.accum = (j == 0) ? mode : !mode;
         v.loop  = (j < n);
         v.addr  = (j < n) ? 4'(j % DEPTH) : 4'hF;
         v.busy  = (j <= n);
         v.valid = (j >= 2) && (j <= n + 1);
         v.done  = (j == n + 1);
         if (v.valid) begin
            idx = (j - 2) % DEPTH;
            pr  = 13'(rom_a[idx]) + 13'(rom_b[idx]);
            if (mode && idx != 0) run = run + pr;
            else                  run = pr;
            hold = run;
         end
         v.sum = hold;
         tbl.push_back(v);
      end
      hold_sum = hold;
   endtask

   task automatic apply_table(input string tag);
      foreach (tbl[j]) begin
         start = tbl[j].start;
         accum = tbl[j].accum;
         loop  = tbl[j].loop;
         @(posedge clock);
         #1;
         check($sformatf("%s[%0d] {addr,busy,valid,done,sum}", tag, j),
               {12'h0, address, busy, sum_valid, done, sum},
               {12'h0, tbl[j].addr, tbl[j].busy, tbl[j].valid, tbl[j].done, tbl[j].sum});
      end
      start = 1'b0;
      loop  = 1'b0;
   endtask

   initial begin
      // Reset state.
      #12;
      check("reset_state", {address, sum, sum_valid, busy, done}, 32'h0);
      load_rom(1'b0);
      hold_sum = '0;
      @(negedge clock);
      reset = 1'b1;

      // Mode 0 single pass: sums 3i, final 0x2D.
      build_run(1, 1'b0, 1'b0, 0);
      apply_table("m0");
      check("m0_final", 32'(sum), 32'h02D);

      // Mode 1 single pass, started at the earliest legal edge: final 0x168.
      build_run(1, 1'b1, 1'b0, 2);
      apply_table("m1");
      check("m1_final", 32'(sum), 32'h168);

      // All-ones ROM words: widest sums.
      load_rom(1'b1);
      build_run(1, 1'b1, 1'b0, 1);
      apply_table("ff_m1");
      check("ff_m1_final", 32'(sum), 32'h1FE0);
      build_run(1, 1'b0, 1'b0, 1);
      apply_table("ff_m0");
      check("ff_m0_final", 32'(sum), 32'h1FE);

      // Two looped passes in mode 1, then loop dropped.
      load_rom(1'b0);
      build_run(2, 1'b1, 1'b0, 1);
      apply_table("loop");
      check("loop_final", 32'(sum), 32'h168);

      // Start pulses during RUN and DRAIN are ignored.
      build_run(1, 1'b0, 1'b1, 2);
      apply_table("start_ign");

      // Asynchronous reset at address 7 of a mode 1 pass.
      start = 1'b1;
      accum = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      check("rst_pre_addr", 32'(address), 32'd7);
      check("rst_pre_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_outputs", {address, sum, sum_valid, busy, done}, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
         check($sformatf("rst_hold[%0d]", c), {address, sum, sum_valid, busy, done}, 32'h0);
      end
      @(negedge clock);
      reset    = 1'b1;
      hold_sum = '0;
      build_run(1, 1'b0, 1'b0, 1);
      apply_table("post_rst");
      check("post_rst_final", 32'(sum), 32'h02D);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
